// File: rtl/sram_ctrl_pkg.sv
// Shared types for the SRAM request sequencer: FSM states, default widths, command word.
package sram_ctrl_pkg;
  localparam int DEF_MEM_WIDTH = 16;
  localparam int DEF_ADD_SIZE  = 10;

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  typedef struct packed {
    logic                     we;
    logic [DEF_ADD_SIZE-1:0]  addr;
    logic [DEF_MEM_WIDTH-1:0] wdata;
  } cmd_t;
endpackage

// File: rtl/sram_req_ctrl_if.sv
// Request/response handshake bundle between a requester and the SRAM sequencer.
interface sram_req_ctrl_if #(
  parameter int MEM_WIDTH = 16,
  parameter int ADD_SIZE  = 10
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [ADD_SIZE-1:0]  req_addr;
  logic [MEM_WIDTH-1:0] req_wdata;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [MEM_WIDTH-1:0] rsp_data;
  logic                 rsp_perr;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_perr
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_perr
  );
endinterface

// File: rtl/sram_cmd_fifo.sv
// Small synchronous FIFO; no bypass, so a pushed entry is visible at the head next cycle.
module sram_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer/occupancy update; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  // Control state register.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents are don't-care while the slot is empty.
  always_ff @(posedge clk1) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end
endmodule

// File: rtl/sram_req_ctrl.sv
// In-order read/write sequencer in front of the single-port parity SRAM.
// SRAM pins come only from registered state, so there is no path from req_* to the RAM.
module sram_req_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int MEM_WIDTH = DEF_MEM_WIDTH,
  parameter int ADD_SIZE  = DEF_ADD_SIZE,
  parameter int CMD_DEPTH = 4,
  parameter int RD_WAIT   = 1
) (
  input  logic                 clk1,
  input  logic                 rst_n,
  sram_req_ctrl_if.slave       bus,
  output logic                 ram_blk_sel,
  output logic                 ram_wr_en,
  output logic                 ram_rd_en,
  output logic [ADD_SIZE-1:0]  ram_addr,
  output logic [MEM_WIDTH-1:0] ram_din,
  input  logic [MEM_WIDTH-1:0] ram_dout,
  input  logic                 ram_parity,
  output logic                 busy
);
  localparam int CW = $clog2(CMD_DEPTH);

  state_t               state_q, state_d;
  cmd_t                 cmd_q, cmd_d, fifo_wdata, fifo_rdata;
  logic [2:0]           wait_q, wait_d;
  logic [MEM_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                 rsp_perr_q, rsp_perr_d;
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW:0]          fifo_count;

  assign fifo_wdata = '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata};
  // Gate ready with reset so nothing looks acceptable while held in reset.
  assign bus.req_ready = rst_n && !fifo_full;
  assign fifo_push     = bus.req_valid && bus.req_ready;

  sram_cmd_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_fifo (
    .clk1 (clk1), .rst_n (rst_n),
    .push (fifo_push), .wdata (fifo_wdata),
    .pop (fifo_pop), .rdata (fifo_rdata),
    .full (fifo_full), .empty (fifo_empty), .count (fifo_count)
  );

  // Next-state: pop in IDLE, one-cycle write, timed read with capture, hold response.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    wait_d     = wait_q;
    rsp_data_d = rsp_data_q;
    rsp_perr_d = rsp_perr_q;
    fifo_pop   = 1'b0;
    case (state_q)
      IDLE: if (!fifo_empty) begin
        fifo_pop = 1'b1;
        cmd_d    = fifo_rdata;
        wait_d   = '0;
        state_d  = fifo_rdata.we ? WRITE : READ;
      end
      WRITE: state_d = IDLE;
      READ: if (wait_q == 3'(RD_WAIT)) begin
        rsp_data_d = ram_dout;
        rsp_perr_d = (^ram_dout) != ram_parity;
        state_d    = RESP;
      end else begin
        wait_d = wait_q + 3'd1;
      end
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM, command and response registers.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      wait_q     <= '0;
      rsp_data_q <= '0;
      rsp_perr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      wait_q     <= wait_d;
      rsp_data_q <= rsp_data_d;
      rsp_perr_q <= rsp_perr_d;
    end
  end

  assign ram_blk_sel   = (state_q == WRITE) || (state_q == READ);
  assign ram_wr_en     = (state_q == WRITE);
  assign ram_rd_en     = (state_q == READ);
  assign ram_addr      = cmd_q.addr;
  assign ram_din       = cmd_q.wdata;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_perr  = rsp_perr_q;
  assign busy          = (state_q != IDLE) || (fifo_count != '0);
endmodule

// File: tb/tb_sram_req_ctrl.sv
// Directed bench: sequencer paired with a behavioural single-port parity SRAM.
module tb_sram_req_ctrl;
  logic        clk1 = 1'b0;
  logic        rst_n = 1'b0;
  logic        ram_blk_sel, ram_wr_en, ram_rd_en, busy;
  logic [9:0]  ram_addr;
  logic [15:0] ram_din, ram_dout, sram_q;
  logic        sram_par_q, par_flip, ram_parity;
  logic [15:0] mem [1024];
  int          n_tests = 0, n_fail = 0;

  sram_req_ctrl_if #(.MEM_WIDTH(16), .ADD_SIZE(10)) bus ();

  sram_req_ctrl #(.MEM_WIDTH(16), .ADD_SIZE(10), .CMD_DEPTH(4), .RD_WAIT(1)) dut (
    .clk1 (clk1), .rst_n (rst_n), .bus (bus.slave),
    .ram_blk_sel (ram_blk_sel), .ram_wr_en (ram_wr_en), .ram_rd_en (ram_rd_en),
    .ram_addr (ram_addr), .ram_din (ram_din), .ram_dout (ram_dout),
    .ram_parity (ram_parity), .busy (busy)
  );

  always #5 clk1 = ~clk1;

  // Behavioural SRAM: synchronous write, registered read data with parity.
  initial for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
  always @(posedge clk1) begin
    if (ram_blk_sel && ram_wr_en) mem[ram_addr] <= ram_din;
    if (ram_blk_sel && ram_rd_en) begin
      sram_q     <= mem[ram_addr];
      sram_par_q <= ^mem[ram_addr];
    end
  end
  assign ram_dout   = sram_q;
  assign ram_parity = sram_par_q ^ par_flip;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a request and hold it until accepted; returns #1 after the accepting edge.
  task automatic push(input logic we, input logic [9:0] addr, input logic [15:0] d);
    int n = 0;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr; bus.req_wdata = d;
    while (!bus.req_ready && n < 200) begin @(negedge clk1); n++; end
    if (n >= 200) chk("push_timeout", 32'(n), 32'd0);
    @(posedge clk1); #1;
    bus.req_valid = 1'b0;
  endtask

  // Wait for a response, check it, and take it.
  task automatic get_rsp(input string tag, input logic [15:0] d, input logic perr);
    int n = 0;
    @(negedge clk1);
    while (!bus.rsp_valid && n < 200) begin @(negedge clk1); n++; end
    chk({tag, "_seen"}, 32'(bus.rsp_valid), 32'd1);
    chk({tag, "_data"}, 32'(bus.rsp_data), 32'(d));
    chk({tag, "_perr"}, 32'(bus.rsp_perr), 32'(perr));
    bus.rsp_ready = 1'b1;
    @(posedge clk1); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin @(negedge clk1); n++; end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    par_flip = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 10'h3; bus.req_wdata = 16'hFFFF;
    bus.rsp_ready = 1'b0;

    // 1. Reset with a request presented.
    repeat (3) @(posedge clk1);
    @(negedge clk1);
    chk("rst_en", {29'd0, ram_blk_sel, ram_wr_en, ram_rd_en}, 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    bus.req_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rel_req_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk1);

    // 2. Write A5A5 to addr 3, then read it back with cycle-exact timing.
    push(1'b1, 10'h3, 16'hA5A5);
    chk("wr_c1", 32'(ram_wr_en), 32'd0);
    @(posedge clk1); #1;
    chk("wr_c2", {29'd0, ram_blk_sel, ram_wr_en, ram_rd_en}, 32'b110);
    chk("wr_addr", 32'(ram_addr), 32'h3);
    @(posedge clk1); #1;
    chk("wr_c3", 32'(ram_wr_en), 32'd0);
    wait_idle();
    @(negedge clk1);
    push(1'b0, 10'h3, 16'h0);
    chk("rd_c1", 32'(ram_rd_en), 32'd0);
    @(posedge clk1); #1;
    chk("rd_c2", {29'd0, ram_blk_sel, ram_wr_en, ram_rd_en}, 32'b101);
    @(posedge clk1); #1;
    chk("rd_c3", {30'd0, ram_rd_en, bus.rsp_valid}, 32'b10);
    @(posedge clk1); #1;
    chk("rd_c4", {30'd0, ram_rd_en, bus.rsp_valid}, 32'b01);
    get_rsp("rd_a5", 16'hA5A5, 1'b0);

    // 3. Fill: park the FSM in RESP, then queue four writes and hold a fifth.
    wait_idle();
    @(negedge clk1);
    push(1'b0, 10'h3, 16'h0);
    repeat (4) @(posedge clk1);
    #1;
    chk("fill_resp", 32'(bus.rsp_valid), 32'd1);
    for (int i = 0; i < 4; i++) push(1'b1, 10'h10 + 10'(i), 16'h2000 + 16'(i));
    chk("fill_full", 32'(bus.req_ready), 32'd0);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 10'h11;
    repeat (3) @(posedge clk1);
    #1;
    chk("fill_held", 32'(bus.req_ready), 32'd0);
    fork
      push(1'b0, 10'h11, 16'h0);
      get_rsp("fill_pre", 16'hA5A5, 1'b0);
    join
    get_rsp("fill_5th", 16'h2001, 1'b0);

    // 4. Parity fault on a read of 0001.
    wait_idle();
    @(negedge clk1);
    push(1'b1, 10'h20, 16'h0001);
    push(1'b0, 10'h20, 16'h0);
    par_flip = 1'b1;
    get_rsp("perr", 16'h0001, 1'b1);
    par_flip = 1'b0;

    // 5. Order and wrap: alternating write/read pairs, responses taken concurrently.
    wait_idle();
    @(negedge clk1);
    fork
      for (int i = 0; i < 8; i++) begin
        push(1'b1, 10'(i), 16'h1000 + 16'(i));
        push(1'b0, 10'(i), 16'h0);
      end
      for (int j = 0; j < 8; j++) get_rsp($sformatf("ord%0d", j), 16'h1000 + 16'(j), 1'b0);
    join

    // 6. Reset during a read with more commands pending.
    wait_idle();
    @(negedge clk1);
    push(1'b0, 10'h5, 16'h0);
    push(1'b1, 10'h30, 16'hDEAD);
    chk("mid_rd1", 32'(ram_rd_en), 32'd1);
    push(1'b1, 10'h31, 16'hBEEF);
    chk("mid_rd2", 32'(ram_rd_en), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_en", {29'd0, ram_blk_sel, ram_wr_en, ram_rd_en}, 32'd0);
    @(negedge clk1);
    rst_n = 1'b1;
    #1;
    chk("post_rst_busy", 32'(busy), 32'd0);
    repeat (4) @(posedge clk1);
    #1;
    chk("post_rst_idle", {30'd0, busy, ram_wr_en}, 32'd0);
    chk("post_rst_mem", 32'(mem[10'h30]), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
